// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath sequencer: states, opcodes,
// ALU op codes, bus/load bit indices and instruction classes.
package datapath_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_F3, S_D,
        S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_STEP
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU, CL_MUL, CL_LDI, CL_LD, CL_NOP, CL_HALT, CL_ILL
    } iclass_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_MUL = 4'd4;
    localparam logic [3:0] ALU_INC = 4'd5;

    // bus_src bit indices (R0-R15 occupy 0..15)
    localparam logic [4:0] BUS_HI     = 5'd16;
    localparam logic [4:0] BUS_LO     = 5'd17;
    localparam logic [4:0] BUS_ZHI    = 5'd18;
    localparam logic [4:0] BUS_ZLO    = 5'd19;
    localparam logic [4:0] BUS_PC     = 5'd20;
    localparam logic [4:0] BUS_MDR    = 5'd21;
    localparam logic [4:0] BUS_INPORT = 5'd22;
    localparam logic [4:0] BUS_C      = 5'd23;

    // ld_en bit indices (R0-R15 occupy 0..15)
    localparam logic [4:0] LD_HI  = 5'd16;
    localparam logic [4:0] LD_LO  = 5'd17;
    localparam logic [4:0] LD_Z   = 5'd18;
    localparam logic [4:0] LD_PC  = 5'd19;
    localparam logic [4:0] LD_MDR = 5'd20;
    localparam logic [4:0] LD_IR  = 5'd21;
    localparam logic [4:0] LD_Y   = 5'd22;
    localparam logic [4:0] LD_MAR = 5'd23;

    function automatic logic [23:0] bit24(input logic [4:0] idx);
        return 24'd1 << idx;
    endfunction

endpackage

// File: rtl/datapath_sequencer_decode.sv
// instr_class_decode: combinational opcode classifier.
// Ports: opcode in; cls, alu_op (ALU/MUL ops) and illegal out.
module instr_class_decode
    import datapath_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_t    cls,
    output logic [3:0] alu_op,
    output logic       illegal
);

    always_comb begin
        cls     = CL_ILL;
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OP_ADD:  begin cls = CL_ALU; alu_op = ALU_ADD; end
            OP_SUB:  begin cls = CL_ALU; alu_op = ALU_SUB; end
            OP_AND:  begin cls = CL_ALU; alu_op = ALU_AND; end
            OP_OR:   begin cls = CL_ALU; alu_op = ALU_OR;  end
            OP_MUL:  begin cls = CL_MUL; alu_op = ALU_MUL; end
            OP_LDI:  cls = CL_LDI;
            OP_LD:   cls = CL_LD;
            OP_NOP:  cls = CL_NOP;
            OP_HALT: cls = CL_HALT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: Moore FSM driving bus source, load enables, ALU op
// and memory read strobe of the shared-bus CPU datapath.
// Ports: clk, reset (async high), ir, mem_ready, [step when SINGLE_STEP_EN]
//        -> bus_src, ld_en, alu_op, md_read, halted, fault (sticky).
// Config: SINGLE_STEP_EN adds step input and the S_STEP pause state.
module datapath_sequencer
    import datapath_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
`ifdef SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [23:0] bus_src,
    output logic [23:0] ld_en,
    output logic [3:0]  alu_op,
    output logic        md_read,
    output logic        halted,
    output logic        fault
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

`ifdef SINGLE_STEP_EN
    localparam state_t FIN = S_STEP;
`else
    localparam state_t FIN = S_F0;
`endif

    state_t          state, state_nxt;
    logic [CW-1:0]   wait_cnt, cnt_nxt;
    logic            set_fault;
    iclass_t         cls;
    logic [3:0]      dec_alu;
    logic            dec_ill;
    logic [4:0]      ra, rb, rc;
    logic            unused_ir;

    assign ra = {1'b0, ir[26:23]};
    assign rb = {1'b0, ir[22:19]};
    assign rc = {1'b0, ir[18:15]};
    assign unused_ir = ^{ir[14:0], dec_ill};

    instr_class_decode u_dec (
        .opcode  (ir[31:27]),
        .cls     (cls),
        .alu_op  (dec_alu),
        .illegal (dec_ill)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
            fault    <= fault | set_fault;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        set_fault = 1'b0;
        bus_src   = '0;
        ld_en     = '0;
        alu_op    = ALU_ADD;
        md_read   = 1'b0;
        halted    = 1'b0;
        unique case (state)
            S_IDLE: begin
`ifdef SINGLE_STEP_EN
                if (step) state_nxt = S_F0;
`else
                state_nxt = S_F0;
`endif
            end
            S_F0: begin
                bus_src   = bit24(BUS_PC);
                ld_en     = bit24(LD_MAR) | bit24(LD_Z);
                alu_op    = ALU_INC;
                state_nxt = S_F1;
            end
            S_F1: begin
                bus_src   = bit24(BUS_ZLO);
                ld_en     = bit24(LD_PC);
                state_nxt = S_F2;
            end
            S_F2: begin
                md_read = 1'b1;
                ld_en   = bit24(LD_MDR);
                if (mem_ready) begin
                    state_nxt = S_F3;
                end else if (wait_cnt == LAST) begin
                    set_fault = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    cnt_nxt = wait_cnt + 1'b1;
                end
            end
            S_F3: begin
                bus_src   = bit24(BUS_MDR);
                ld_en     = bit24(LD_IR);
                state_nxt = S_D;
            end
            S_D: begin
                case (cls)
                    CL_NOP:  state_nxt = FIN;
                    CL_HALT: state_nxt = S_HALT;
                    CL_ILL: begin
                        set_fault = 1'b1;
                        state_nxt = FIN;
                    end
                    default: state_nxt = S_T3;
                endcase
            end
            S_T3: begin
                bus_src   = bit24(rb);
                ld_en     = bit24(LD_Y);
                state_nxt = S_T4;
            end
            S_T4: begin
                ld_en = bit24(LD_Z);
                if (cls == CL_LDI || cls == CL_LD) begin
                    bus_src = bit24(BUS_C);
                    alu_op  = ALU_ADD;
                end else begin
                    bus_src = bit24(rc);
                    alu_op  = dec_alu;
                end
                state_nxt = S_T5;
            end
            S_T5: begin
                bus_src = bit24(BUS_ZLO);
                case (cls)
                    CL_MUL: begin
                        ld_en     = bit24(LD_LO);
                        state_nxt = S_T6;
                    end
                    CL_LD: begin
                        ld_en     = bit24(LD_MAR);
                        state_nxt = S_T6;
                    end
                    default: begin
                        ld_en     = bit24(ra);
                        state_nxt = FIN;
                    end
                endcase
            end
            S_T6: begin
                if (cls == CL_MUL) begin
                    bus_src   = bit24(BUS_ZHI);
                    ld_en     = bit24(LD_HI);
                    state_nxt = FIN;
                end else begin
                    md_read = 1'b1;
                    ld_en   = bit24(LD_MDR);
                    if (mem_ready) begin
                        state_nxt = S_T7;
                    end else if (wait_cnt == LAST) begin
                        set_fault = 1'b1;
                        state_nxt = S_HALT;
                    end else begin
                        cnt_nxt = wait_cnt + 1'b1;
                    end
                end
            end
            S_T7: begin
                bus_src   = bit24(BUS_MDR);
                ld_en     = bit24(ra);
                state_nxt = FIN;
            end
            S_HALT: halted = 1'b1;
            S_STEP: begin
`ifdef SINGLE_STEP_EN
                if (step) state_nxt = S_F0;
`else
                state_nxt = S_F0;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: randomized instruction
// stream against a cycle-list model built from the control sequence.
module tb_datapath_sequencer;

    localparam int MEM_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;
    logic        mem_ready;
    logic [23:0] bus_src;
    logic [23:0] ld_en;
    logic [3:0]  alu_op;
    logic        md_read;
    logic        halted;
    logic        fault;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b1;
`endif

    always #5 clk = ~clk;

    datapath_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .ir        (ir),
        .mem_ready (mem_ready),
        .bus_src   (bus_src),
        .ld_en     (ld_en),
        .alu_op    (alu_op),
        .md_read   (md_read),
        .halted    (halted),
        .fault     (fault)
    );

    typedef struct {
        logic [23:0] bus;
        logic [23:0] ld;
        logic [3:0]  alu;
        logic        md;
        int          mr;
        logic        flt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_fault = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] oh(input int i);
        return (i < 0) ? 24'd0 : (24'd1 << i);
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input int ra,
                                          input int rb, input int rc);
        return {op, 4'(ra), 4'(rb), 4'(rc), 15'h0};
    endfunction

    function automatic logic [3:0] op_alu(input logic [4:0] op);
        case (op)
            5'd4:    return 4'd1;
            5'd5:    return 4'd2;
            5'd6:    return 4'd3;
            5'd15:   return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    // mr: 0/1 driven on mem_ready that cycle, 2 = don't care (random)
    task automatic push(input int bus, input logic [23:0] ld,
                        input logic [3:0] alu, input logic md, input int mr);
        exp_t e;
        e.bus = oh(bus);
        e.ld  = ld;
        e.alu = alu;
        e.md  = md;
        e.mr  = mr;
        e.flt = exp_fault;
        q.push_back(e);
    endtask

    task automatic push_wait(input int d);
        for (int k = 0; k < d; k++) push(-1, oh(20), 0, 1'b1, 0);
        push(-1, oh(20), 0, 1'b1, 1);
    endtask

    task automatic push_fetch(input int d_fetch);
        push(20, oh(23) | oh(18), 4'd5, 1'b0, 2);
        push(19, oh(19), 0, 1'b0, 2);
        push_wait(d_fetch);
        push(21, oh(21), 0, 1'b0, 2);
        push(-1, 24'd0, 0, 1'b0, 2);
    endtask

    task automatic build(input logic [4:0] op, input int ra, input int rb,
                         input int rc, input int d_fetch, input int d_mem);
        push_fetch(d_fetch);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd15: begin
                push(rb, oh(22), 0, 1'b0, 2);
                push(rc, oh(18), op_alu(op), 1'b0, 2);
                if (op == 5'd15) begin
                    push(19, oh(17), 0, 1'b0, 2);
                    push(18, oh(16), 0, 1'b0, 2);
                end else begin
                    push(19, oh(ra), 0, 1'b0, 2);
                end
            end
            5'd0, 5'd1: begin
                push(rb, oh(22), 0, 1'b0, 2);
                push(23, oh(18), 0, 1'b0, 2);
                if (op == 5'd1) begin
                    push(19, oh(ra), 0, 1'b0, 2);
                end else begin
                    push(19, oh(23), 0, 1'b0, 2);
                    push_wait(d_mem);
                    push(21, oh(ra), 0, 1'b0, 2);
                end
            end
            5'd26: ;
            default: exp_fault = 1'b1;
        endcase
`ifdef SINGLE_STEP_EN
        push(-1, 24'd0, 0, 1'b0, 2);
`endif
    endtask

    task automatic run_q(input logic [31:0] new_ir);
        int idx = 0;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            @(negedge clk);
            if (idx == 0) ir = new_ir;
            mem_ready = (e.mr == 2) ? 1'($urandom_range(0, 1)) : 1'(e.mr);
            check($sformatf("bus_src c%0d", idx), {8'h0, bus_src}, {8'h0, e.bus});
            check($sformatf("ld_en c%0d", idx), {8'h0, ld_en}, {8'h0, e.ld});
            check($sformatf("alu_op c%0d", idx), {28'h0, alu_op}, {28'h0, e.alu});
            check($sformatf("md_read c%0d", idx), {31'h0, md_read}, {31'h0, e.md});
            check($sformatf("halted c%0d", idx), {31'h0, halted}, 32'h0);
            check($sformatf("fault c%0d", idx), {31'h0, fault}, {31'h0, e.flt});
            idx++;
        end
    endtask

    task automatic check_quiet(input string tag, input logic exp_halt,
                               input logic exp_flt);
        check({tag, " bus_src"}, {8'h0, bus_src}, 32'h0);
        check({tag, " ld_en"}, {8'h0, ld_en}, 32'h0);
        check({tag, " md_read"}, {31'h0, md_read}, 32'h0);
        check({tag, " alu_op"}, {28'h0, alu_op}, 32'h0);
        check({tag, " halted"}, {31'h0, halted}, {31'h0, exp_halt});
        check({tag, " fault"}, {31'h0, fault}, {31'h0, exp_flt});
    endtask

    task automatic halt_cycles(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            check_quiet(tag, 1'b1, exp_fault);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1 check_quiet("reset", 1'b0, 1'b0);
        @(negedge clk);
        check_quiet("reset hold", 1'b0, 1'b0);
        reset = 1'b0;
        exp_fault = 1'b0;
        #1 check_quiet("idle", 1'b0, 1'b0);
    endtask

    logic [4:0] op_tab [10] = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd5,
                                5'd6, 5'd15, 5'd26, 5'd31, 5'd2};

    initial begin
        reset     = 1'b1;
        ir        = 32'h0;
        mem_ready = 1'b0;
        do_reset();

        // add R2,R3,R4, memory ready immediately
        build(5'd3, 2, 3, 4, 0, 0);
        run_q(mk_ir(5'd3, 2, 3, 4));
        // sub with 5 stall cycles in fetch
        build(5'd4, 9, 1, 14, 5, 0);
        run_q(mk_ir(5'd4, 9, 1, 14));
        // mul R6,R7
        build(5'd15, 6, 6, 7, 0, 0);
        run_q(mk_ir(5'd15, 6, 6, 7));
        // illegal opcode sets sticky fault, continues as NOP
        build(5'd31, 1, 2, 3, 1, 0);
        run_q(mk_ir(5'd31, 1, 2, 3));
        build(5'd0, 5, 8, 0, 0, 3);
        run_q(mk_ir(5'd0, 5, 8, 0));

        for (int n = 0; n < 30; n++) begin
            logic [4:0] op;
            int ra, rb, rc, df, dm;
            op = op_tab[$urandom_range(0, 9)];
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            rc = $urandom_range(0, 15);
            df = $urandom_range(0, 6);
            dm = $urandom_range(0, MEM_TIMEOUT - 2);
            build(op, ra, rb, rc, df, dm);
            run_q(mk_ir(op, ra, rb, rc));
        end

        // halt instruction, then reset clears halted/fault
        push_fetch(0);
        run_q(mk_ir(5'd27, 0, 0, 0));
        halt_cycles("halt", 4);
        do_reset();

        // reset in T4 of ld: outputs drop at once, Ra never loaded
        build(5'd0, 12, 3, 0, 0, 0);
        while (q.size() > 7) void'(q.pop_back());
        run_q(mk_ir(5'd0, 12, 3, 0));
        #2 reset = 1'b1;
        #1 check_quiet("mid-ld reset", 1'b0, 1'b0);
        @(negedge clk);
        mem_ready = 1'b1;
        check_quiet("mid-ld hold", 1'b0, 1'b0);
        check("mid-ld Ra load", {31'h0, ld_en[12]}, 32'h0);
        reset = 1'b0;
        exp_fault = 1'b0;
        #1 check_quiet("mid-ld idle", 1'b0, 1'b0);
        build(5'd3, 2, 3, 4, 0, 0);
        run_q(mk_ir(5'd3, 2, 3, 4));

        // memory never ready: 16 cycles in F2, then fault + halt
        push(20, oh(23) | oh(18), 4'd5, 1'b0, 2);
        push(19, oh(19), 0, 1'b0, 2);
        for (int k = 0; k < MEM_TIMEOUT; k++) push(-1, oh(20), 0, 1'b1, 0);
        run_q(mk_ir(5'd3, 1, 1, 1));
        exp_fault = 1'b1;
        halt_cycles("timeout", 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
